vram_arbiter: RTL

Sequencer and arbiter for the single external video SRAM (19-bit `va`, 8-bit `vd`, `n_vrd`/`n_vwr`). It shares that SRAM between three requesters: screen fetch (highest priority), the CPU memory path, and a DMA/blitter port. It issues fixed 2-cycle SRAM accesses on `clk28` and returns read data with a one-cycle acknowledge. A DMA anti-starvation counter bounds how long the CPU can lock out DMA.

---
 rtl/vram_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Video SRAM sequencer: screen > CPU > DMA (with DMA anti-starvation), fixed T1/T2 access, req->ack 3 cycles.
// Requests are levels held until served; a port is never re-granted at its own T2-exit or ack-end edge.
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DMA_STARVE = 8
) (
  input  logic              clk28,
  input  logic              rst,
  input  logic              scr_req,
  input  logic [ADDR_W-1:0] scr_addr,
  output logic [7:0]        scr_rdata,
  output logic              scr_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic [7:0]        dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] va,
  output logic [7:0]        vd_o,
  output logic              vd_oe,
  input  logic [7:0]        vd_i,
  output logic              n_vrd,
  output logic              n_vwr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, T1, T2} state_t;

  localparam logic [1:0] OWN_SCR = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_DMA = 2'd2;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_own, w_own_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_va, w_va_nxt;
  logic [7:0]        r_vd_o, w_vd_o_nxt;
  logic [3:0]        r_starve, w_starve_nxt;
  logic              r_n_vrd, r_n_vwr, r_vd_oe, r_busy;
  logic              r_scr_valid, r_cpu_ack, r_dma_ack;
  logic [7:0]        r_scr_rdata, r_cpu_rdata, r_dma_rdata;
  logic              w_t2_exit, w_arb, w_grant, w_dma_first;
  logic              w_el_scr, w_el_cpu, w_el_dma;

  always_ff @(posedge clk28) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_t2_exit    = (r_state == T2);
    w_arb        = (r_state == IDLE) || w_t2_exit;
    // a port's own T2-exit edge and ack-end edge never re-grant it
    w_el_scr     = scr_req && !(w_t2_exit && r_own == OWN_SCR) && !r_scr_valid;
    w_el_cpu     = cpu_req && !(w_t2_exit && r_own == OWN_CPU) && !r_cpu_ack;
    w_el_dma     = dma_req && !(w_t2_exit && r_own == OWN_DMA) && !r_dma_ack;
    w_dma_first  = (r_starve == 4'(DMA_STARVE)) && w_el_dma;
    w_grant      = 1'b0;
    w_own_nxt    = r_own;
    w_we_nxt     = r_we;
    w_va_nxt     = r_va;
    w_vd_o_nxt   = r_vd_o;
    w_starve_nxt = r_starve;
    case (r_state)
      T1:      w_state_nxt = T2;
      default: w_state_nxt = IDLE;
    endcase
    if (w_arb) begin
      if (w_el_scr) begin
        w_grant   = 1'b1;
        w_own_nxt = OWN_SCR;
        w_we_nxt  = 1'b0;
        w_va_nxt  = scr_addr;
      end else if (w_el_cpu && !w_dma_first) begin
        w_grant   = 1'b1;
        w_own_nxt = OWN_CPU;
        w_we_nxt  = cpu_we;
        w_va_nxt  = cpu_addr;
        if (cpu_we) w_vd_o_nxt = cpu_wdata;
        if (w_el_dma && r_starve != 4'hF) w_starve_nxt = r_starve + 4'd1;
      end else if (w_el_dma) begin
        w_grant      = 1'b1;
        w_own_nxt    = OWN_DMA;
        w_we_nxt     = dma_we;
        w_va_nxt     = dma_addr;
        if (dma_we) w_vd_o_nxt = dma_wdata;
        w_starve_nxt = 4'd0;
      end
      if (w_grant) w_state_nxt = T1;
    end
    if (!dma_req) w_starve_nxt = 4'd0;
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      r_own       <= OWN_SCR;
      r_we        <= 1'b0;
      r_va        <= '0;
      r_vd_o      <= '0;
      r_starve    <= '0;
      r_n_vrd     <= 1'b1;
      r_n_vwr     <= 1'b1;
      r_vd_oe     <= 1'b0;
      r_busy      <= 1'b0;
      r_scr_valid <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_scr_rdata <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_own       <= w_own_nxt;
      r_we        <= w_we_nxt;
      r_va        <= w_va_nxt;
      r_vd_o      <= w_vd_o_nxt;
      r_starve    <= w_starve_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_n_vrd     <= !((w_state_nxt != IDLE) && !w_we_nxt);
      r_vd_oe     <= (w_state_nxt != IDLE) && w_we_nxt;
      // write strobe only in T2 so address and data get a full setup cycle
      r_n_vwr     <= !((w_state_nxt == T2) && w_we_nxt);
      r_scr_valid <= w_t2_exit && (r_own == OWN_SCR);
      r_cpu_ack   <= w_t2_exit && (r_own == OWN_CPU);
      r_dma_ack   <= w_t2_exit && (r_own == OWN_DMA);
      if (w_t2_exit && !r_we) begin
        case (r_own)
          OWN_SCR: r_scr_rdata <= vd_i;
          OWN_CPU: r_cpu_rdata <= vd_i;
          default: r_dma_rdata <= vd_i;
        endcase
      end
    end
  end

  assign va        = r_va;
  assign vd_o      = r_vd_o;
  assign vd_oe     = r_vd_oe;
  assign n_vrd     = r_n_vrd;
  assign n_vwr     = r_n_vwr;
  assign busy      = r_busy;
  assign scr_valid = r_scr_valid;
  assign cpu_ack   = r_cpu_ack;
  assign dma_ack   = r_dma_ack;
  assign scr_rdata = r_scr_rdata;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;

endmodule
